// File: rtl/lsu_if.sv
// LSU handshake bundles: request/response port and data-bus port.
// master drives the request side of each bundle, slave answers it.
interface lsu_req_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_misaligned_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i,
    output req_unsigned_i, addr_i, wdata_i, rd_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o,
    input  rsp_rd_o, rsp_misaligned_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i,
    input  req_unsigned_i, addr_i, wdata_i, rd_i,
    output req_ready_o, rsp_valid_o, rsp_data_o,
    output rsp_rd_o, rsp_misaligned_o, rsp_err_o
  );
endinterface

interface lsu_bus_if;
  logic        bus_valid_o;
  logic        bus_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_valid_o, bus_addr_o, bus_we_o,
    output bus_be_o, bus_wdata_o,
    input  bus_ready_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_valid_o, bus_addr_o, bus_we_o,
    input  bus_be_o, bus_wdata_o,
    output bus_ready_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one bus access per request, aligned/extended loads.
// Ports: clk_i, rst_i (sync, high); req = lsu_req_if.slave; bus = lsu_bus_if.master.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clk_i,
  input  logic      rst_i,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t state_q, state_d;

  logic          we_q, uns_q, mis_q, err_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, data_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt_q;

  logic        accept, mis_in;
  logic        in_req, in_wait, in_resp;
  logic        done, abort, to_hit;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wd_c, shifted, ld_c;

  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);
  assign in_resp = (state_q == RESP);
  assign accept  = req.req_valid_i && (state_q == IDLE);

  always_comb begin
    mis_in = 1'b0;
    unique case (1'b1)
      (req.req_size_i == 2'b00): mis_in = 1'b0;
      (req.req_size_i == 2'b01): mis_in = req.addr_i[0];
      (req.req_size_i == 2'b10): mis_in = |req.addr_i[1:0];
      default:                   mis_in = 1'b1;
    endcase
  end

  // A load finishes only when data arrives; a store on the ready handshake.
  assign done =
    (in_req && bus.bus_ready_i &&
     (we_q || bus.bus_rvalid_i)) ||
    (in_wait && bus.bus_rvalid_i);

  // Last allowed REQ/WAIT cycle: a real completion still wins.
  assign to_hit = TO_EN && (cnt_q == CNT_LAST) &&
                  (in_req || in_wait);
  assign abort  = to_hit && !done;

  assign off     = addr_q[1:0];
  assign shifted = bus.bus_rdata_i >> {off, 3'b000};

  always_comb begin
    be_c = 4'b0000;
    wd_c = '0;
    ld_c = '0;
    unique case (1'b1)
      (size_q == 2'b00): begin
        be_c = 4'b0001 << off;
        wd_c = {4{wdata_q[7:0]}};
        ld_c = {{24{shifted[7] & ~uns_q}},
                shifted[7:0]};
      end
      (size_q == 2'b01): begin
        be_c = 4'b0011 << off;
        wd_c = {2{wdata_q[15:0]}};
        ld_c = {{16{shifted[15] & ~uns_q}},
                shifted[15:0]};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
        ld_c = shifted;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = mis_in ? RESP : REQ;
      REQ:
        if (done || abort)         state_d = RESP;
        else if (bus.bus_ready_i)  state_d = WAIT;
      WAIT:
        if (done || abort) state_d = RESP;
      RESP:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= req.req_we_i;
        uns_q   <= req.req_unsigned_i;
        size_q  <= req.req_size_i;
        addr_q  <= req.addr_i;
        wdata_q <= req.wdata_i;
        rd_q    <= req.rd_i;
        mis_q   <= mis_in;
        err_q   <= 1'b0;
        data_q  <= '0;
        cnt_q   <= '0;
      end else if (in_req || in_wait) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (done && !we_q) data_q <= ld_c;
      if (abort)         err_q  <= 1'b1;
    end
  end

  assign req.req_ready_o      = (state_q == IDLE);
  assign req.rsp_valid_o      = in_resp;
  assign req.rsp_data_o       = in_resp ? data_q : '0;
  assign req.rsp_rd_o         = in_resp ? rd_q : '0;
  assign req.rsp_misaligned_o = in_resp && mis_q;
  assign req.rsp_err_o        = in_resp && err_q;

  assign bus.bus_valid_o = in_req;
  assign bus.bus_addr_o  =
    in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.bus_we_o    = in_req && we_q;
  assign bus.bus_be_o    = in_req ? be_c : 4'b0000;
  assign bus.bus_wdata_o =
    (in_req && we_q) ? wd_c : '0;
endmodule
